// File: rtl/bus_slave_ram.sv
// bus_slave_ram: word-addressed single-port RAM slave on the system bus.
// A request (cs_=0, as_=0) is latched in IDLE. The programmed number of wait
// cycles is then inserted, and the access completes with a one-cycle
// active-low rdy_ pulse. rd_data is non-zero only while rdy_ is low, so the
// bus read mux can simply OR the slaves together.
// ADDR_W must be below 30; the upper address bits are ignored, which makes
// the RAM alias every 2^ADDR_W words.

module bus_slave_ram #(
  parameter int ADDR_W  = 8,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);
  localparam logic [3:0] WR_WAIT_C = 4'(WR_WAIT);
  localparam logic       BUS_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic [31:0]         r_wr_data;
  logic [31:0]         r_rd_data;
  logic                r_rdy_n;
  logic [31:0]         r_mem [DEPTH];

  logic                w_req;
  logic [3:0]          w_req_wait;
  logic                w_ack_go;
  logic [ADDR_W-1:0]   w_ack_addr;
  logic                w_ack_rw;
  logic [31:0]         w_ack_data;
  logic                w_mem_we;
  logic                w_unused_addr;

  // A request is present only while this slave is selected and strobed.
  assign w_req         = ~cs_ & ~as_;
  assign w_req_wait    = (rw == BUS_READ) ? RD_WAIT_C : WR_WAIT_C;
  assign w_unused_addr = ^addr[29:ADDR_W];

  // Decide whether the coming edge enters ACK, and with which access.
  // A zero-wait access is served straight from the bus inputs; otherwise
  // the latched copy is used, so late changes of wr_data cannot leak in.
  always_comb begin
    w_ack_go   = 1'b0;
    w_ack_addr = r_addr;
    w_ack_rw   = r_rw;
    w_ack_data = r_wr_data;
    case (r_state)
      ST_IDLE: begin
        if (w_req && (w_req_wait == 4'd0)) begin
          w_ack_go   = 1'b1;
          w_ack_addr = addr[ADDR_W-1:0];
          w_ack_rw   = rw;
          w_ack_data = wr_data;
        end else begin
          w_ack_go   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (w_req && (r_cnt == 4'd1)) begin
          w_ack_go = 1'b1;
        end else begin
          w_ack_go = 1'b0;
        end
      end
      default: begin
        w_ack_go = 1'b0;
      end
    endcase
  end

  // The write is committed only on ACK entry and never while reset is held,
  // so aborted or reset accesses leave the RAM untouched.
  assign w_mem_we = w_ack_go & (w_ack_rw != BUS_READ) & reset;

  // RAM array: no reset, contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_ack_addr] <= w_ack_data;
    end
  end

  // Access FSM: latch the request, count wait cycles, abort on a dropped strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_wr_data <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr    <= addr[ADDR_W-1:0];
            r_rw      <= rw;
            r_wr_data <= wr_data;
            r_cnt     <= w_req_wait;
            r_state   <= (w_req_wait == 4'd0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!w_req) begin
            r_cnt   <= 4'd0;
            r_state <= ST_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ST_ACK;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= 4'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered bus outputs: rdy_ low and read data present for exactly the ACK cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_n   <= 1'b1;
      r_rd_data <= 32'd0;
    end else if (w_ack_go) begin
      r_rdy_n   <= 1'b0;
      r_rd_data <= (w_ack_rw == BUS_READ) ? r_mem[w_ack_addr] : 32'd0;
    end else begin
      r_rdy_n   <= 1'b1;
      r_rd_data <= 32'd0;
    end
  end

  assign rd_data = r_rd_data;
  assign rdy_    = r_rdy_n;

  bus_slave_ram_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .rdy_    (r_rdy_n),
    .rd_data (r_rd_data)
  );

endmodule

// Output protocol checker: rd_data is zero outside ACK, rdy_ pulses last one cycle.
module bus_slave_ram_chk (
  input logic        clk,
  input logic        reset,
  input logic        rdy_,
  input logic [31:0] rd_data
);

  a_rd_data_zero_when_idle: assert property (
    @(posedge clk) disable iff (!reset) rdy_ |-> (rd_data == 32'd0)
  );

  a_rdy_single_cycle: assert property (
    @(posedge clk) disable iff (!reset) !rdy_ |=> rdy_
  );

endmodule

// File: tb/tb_bus_slave_ram.sv
// Bench for bus_slave_ram: two instances (default waits, and RD_WAIT=3 /
// WR_WAIT=2) driven by a bus-master task. Expected responses (data and the
// cycle of the rdy_ pulse) are queued at request time from a simple array
// model of the RAM; a negedge monitor pops and compares on every rdy_ pulse
// and checks rd_data is zero otherwise.

module tb_bus_slave_ram;

  localparam int DEPTH = 256;

  typedef struct {
    int          d;
    logic [31:0] data;
    longint      cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       cs_n;
  logic [1:0]       as_n;
  logic [1:0]       rw_s;
  logic [1:0][29:0] addr_s;
  logic [1:0][31:0] wdata_s;
  logic [1:0][31:0] rdata_s;
  logic [1:0]       rdy_n;

  longint      cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [2][DEPTH];
  bit          ref_vld [2][DEPTH];

  bus_slave_ram #(.ADDR_W(8), .RD_WAIT(1), .WR_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .cs_(cs_n[0]), .as_(as_n[0]), .rw(rw_s[0]),
    .addr(addr_s[0]), .wr_data(wdata_s[0]), .rd_data(rdata_s[0]), .rdy_(rdy_n[0])
  );

  bus_slave_ram #(.ADDR_W(8), .RD_WAIT(3), .WR_WAIT(2)) u_dut1 (
    .clk(clk), .reset(reset), .cs_(cs_n[1]), .as_(as_n[1]), .rw(rw_s[1]),
    .addr(addr_s[1]), .wr_data(wdata_s[1]), .rd_data(rdata_s[1]), .rdy_(rdy_n[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d, input logic is_read);
    if (is_read) return (d == 0) ? 1 : 3;
    return (d == 0) ? 0 : 2;
  endfunction

  // Monitor: every negedge, check idle outputs or match a pulse to the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (rdy_n[d] === 1'b1) begin
          n_cmp++;
          if (rdata_s[d] !== 32'd0) begin
            n_err++;
            $display("FAIL idle_rd_data dut%0d cyc=%0d: got %h, expected 00000000", d, cyc, rdata_s[d]);
          end
        end else begin
          n_cmp++;
          if (exp_q.size() == 0 || exp_q[0].d != d) begin
            n_err++;
            $display("FAIL unexpected_rdy dut%0d cyc=%0d: got rdy_=%b, expected 1", d, cyc, rdy_n[d]);
          end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || rdata_s[d] !== e.data) begin
              n_err++;
              $display("FAIL ack dut%0d: got cyc=%0d data=%h, expected cyc=%0d data=%h",
                       d, cyc, rdata_s[d], e.cyc, e.data);
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete bus access with an expected response queued for the monitor.
  task automatic access(input int d, input logic is_read, input logic [29:0] a, input logic [31:0] data);
    exp_t e;
    int   idx;
    bit   got;
    idx = int'(a) % DEPTH;
    @(negedge clk);
    cs_n[d] = 1'b0; as_n[d] = 1'b0; rw_s[d] = is_read; addr_s[d] = a; wdata_s[d] = data;
    e.d   = d;
    e.cyc = cyc + 1 + wait_of(d, is_read);
    if (is_read) begin
      e.data = ref_mem[d][idx];
    end else begin
      e.data = 32'd0;
      ref_mem[d][idx] = data;
      ref_vld[d][idx] = 1'b1;
    end
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy_n[d] == 1'b0) begin
        got = 1'b1;
        break;
      end
      // request already latched: changing wr_data now must not matter
      if (!is_read) wdata_s[d] = ~data;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL rdy_timeout dut%0d addr=%h: got no rdy_ in 40 cycles, expected one", d, a);
      exp_q.delete();
    end
    cs_n[d] = 1'b1; as_n[d] = 1'b1;
    addr_s[d] = 30'($urandom); wdata_s[d] = $urandom;
  endtask

  // Access whose strobe is dropped after k negedges; no response may appear.
  task automatic abort_access(input int d, input logic is_read, input logic [29:0] a,
                              input logic [31:0] data, input int k);
    @(negedge clk);
    cs_n[d] = 1'b0; as_n[d] = 1'b0; rw_s[d] = is_read; addr_s[d] = a; wdata_s[d] = data;
    idle(k);
    as_n[d] = 1'b1; cs_n[d] = 1'b1;
    idle(6);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [29:0] a;
    logic        rd;
    int          d;
    cs_n = 2'b11; as_n = 2'b11; rw_s = 2'b00; addr_s = '0; wdata_s = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    mon_en = 1'b1;

    // reset held with a request pending on both slaves: no response
    @(negedge clk);
    cs_n = 2'b00; as_n = 2'b00; rw_s = 2'b11;
    idle(5);
    cs_n = 2'b11; as_n = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // default waits: write then read
    access(0, 1'b0, 30'h1, 32'h97);
    access(0, 1'b1, 30'h1, 32'h0);

    // RD_WAIT=3, WR_WAIT=2
    access(1, 1'b0, 30'h5, 32'h98);
    access(1, 1'b1, 30'h5, 32'h0);

    // aborted read and aborted write; old value must survive
    abort_access(1, 1'b1, 30'h5, 32'h0, 2);
    abort_access(1, 1'b0, 30'h5, 32'h0BAD_0BAD, 1);
    access(1, 1'b1, 30'h5, 32'h0);

    // another slave selected: no response
    @(negedge clk);
    as_n = 2'b00; cs_n = 2'b11; rw_s = 2'b01;
    idle(6);
    as_n = 2'b11;

    // address aliasing: 0x100 wraps to word 0
    access(0, 1'b0, 30'h100, 32'h99);
    access(0, 1'b1, 30'h0, 32'h0);

    // reset during the WAIT of a write: dropped, RAM unchanged
    @(negedge clk);
    cs_n[1] = 1'b0; as_n[1] = 1'b0; rw_s[1] = 1'b0; addr_s[1] = 30'h5; wdata_s[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    cs_n[1] = 1'b1; as_n[1] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    access(1, 1'b1, 30'h5, 32'h0);

    // randomized traffic, upper address bits random to exercise wrap
    for (int i = 0; i < 80; i++) begin
      d = int'($urandom_range(0, 1));
      a = 30'($urandom);
      a[7:0] = 8'($urandom_range(0, 31));
      rd = 1'($urandom_range(0, 1));
      if (rd && !ref_vld[d][int'(a[7:0])]) rd = 1'b0;
      access(d, rd, a, $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    idle(6);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_responses: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_slave_ram.md
Name: bus_slave_ram

Overview:
Word-addressed bus responder: a single-port RAM behind the system bus with programmable wait states. It answers accesses from bus masters such as the CPU bus interface and plugs into the bus as any slave does: the address decoder drives cs_, and the read-data mux ORs its rd_data. It latches the request, inserts the configured wait cycles, and returns a one-cycle rdy_ pulse that completes the access.

Parameters:
ADDR_W, 8, local word-address bits; depth = 2^ADDR_W words
RD_WAIT, 1, wait cycles inserted before rdy_ on reads (0..15)
WR_WAIT, 0, wait cycles inserted before rdy_ on writes (0..15)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset
cs_  input  1  chip select from address decoder, active-low
as_  input  1  address strobe, active-low
rw  input  1  READ (1) / WRITE (0), same encoding as the master's bus_rw
addr  input  30  word address; only addr[ADDR_W-1:0] is used
wr_data  input  32  write data
rd_data  output  32  read data; 0 whenever rdy_ is high
rdy_  output  1  ready, active-low, one-cycle pulse completing an access

Behaviour:
- Reset (reset=0, async): state=IDLE, rdy_=1, rd_data=0, wait counter=0. RAM contents are not cleared. An in-flight access is dropped: no write, no rdy_.
- All outputs are registered.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On a clk edge with cs_=0 and as_=0, latch addr[ADDR_W-1:0], rw and wr_data.
  - Load the counter with RD_WAIT (rw=1) or WR_WAIT (rw=0).
  - Counter 0 -> ACK; otherwise -> WAIT.
- WAIT:
  - Decrement the counter each cycle; when it reaches 1, go to ACK on the next edge.
  - If cs_=1 or as_=1 is sampled in WAIT: abort to IDLE, no write, no rdy_.
- Entering ACK (the registered edge):
  - Read: rd_data <= mem[latched addr].
  - Write: mem[latched addr] <= latched wr_data; rd_data stays 0.
  - rdy_ <= 0.
  - ACK lasts exactly one cycle, then -> IDLE with rdy_=1 and rd_data=0.
- Latency: request sampled at edge N -> rdy_ low in cycle N+1+W (W = RD_WAIT or WR_WAIT) -> rdy_ high again at N+2+W.
- Master contract: hold addr/rw/wr_data/as_ stable until rdy_ is seen low, and deassert as_ in the cycle after rdy_.
- as_ and cs_ are ignored while in ACK. If both are still low when IDLE samples again, that is a new access, so the minimum spacing between back-to-back accesses is 2+W cycles.
- Write committed only on ACK entry; an aborted or reset access never modifies the RAM.
- Address wrap: addr bits above ADDR_W-1 are ignored, so addr = 2^ADDR_W aliases word 0.
- cs_=1 with as_=0 (access to another slave): no response, state unchanged.
- rw=WRITE data is taken from the latched copy, so wr_data changes after the request edge have no effect.

Test Plan:
- Reset: hold reset=0 with as_=cs_=0 -> rdy_=1, rd_data=0 throughout; release, then first access behaves normally.
- Write then read, defaults: write addr=0x1, data=0x97 -> rdy_ low exactly 1 cycle at request+1. Read addr=0x1 -> rdy_ low at request+2 with rd_data=0x97; rd_data=0 the cycle before and after.
- Wait states RD_WAIT=3, WR_WAIT=2: write 0x98 to addr 0x5 -> rdy_ at +3. Read 0x5 -> rdy_ at +4 with data 0x98; rdy_ never low early.
- Abort: RD_WAIT=3; read request, deassert as_ after 1 WAIT cycle -> no rdy_ pulse. A write aborted likewise leaves the old value (0x98) readable.
- Unselected and aliasing, ADDR_W=8: as_=0, cs_=1 -> no rdy_. Write 0x99 to addr 0x100 -> read of addr 0x0 returns 0x99.
- Reset mid-access: assert reset during WAIT of a write to 0x5 -> rdy_ stays 1; after release, read 0x5 returns the pre-reset value.
